// File: rtl/sync_pkg.sv
// Shared definitions for the synchronisation register primitives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sync_pkg;

    // Occupancy of an M-structure register.
    typedef enum logic {
        SYNC_EMPTY = 1'b0,
        SYNC_FULL  = 1'b1
    } sync_state_t;

    // Round-robin pointer encodings: which port wins the next conflict.
    localparam logic ARB_PORT0 = 1'b0;
    localparam logic ARB_PORT1 = 1'b1;

endpackage

// File: rtl/std_sync_reg_2r_if.sv
// Handshake bundle between one writer, two readers and the sync register.
// Latency: n/a (wiring only).
// Backpressure: requests are held high until the matching done pulse.
interface std_sync_reg_2r_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in;
    logic             write_en;
    logic             read_en_0;
    logic             read_en_1;
    logic [WIDTH-1:0] out_0;
    logic [WIDTH-1:0] out_1;
    logic             write_done;
    logic             read_done_0;
    logic             read_done_1;

    // Producer/consumer side.
    modport master (
        output in, write_en, read_en_0, read_en_1,
        input  out_0, out_1, write_done, read_done_0, read_done_1
    );

    // Register side.
    modport slave (
        input  in, write_en, read_en_0, read_en_1,
        output out_0, out_1, write_done, read_done_0, read_done_1
    );
endinterface

// File: rtl/std_rr_arb2.sv
// Two-requester round-robin arbiter with one-hot grant and advance enable.
// Latency: grant is combinational from req; pointer updates on the edge when adv=1.
// Backpressure: none; a requester without grant simply keeps requesting.
module std_rr_arb2
    import sync_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);

    logic ptr_q;

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr_q == ARB_PORT0) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer flips only when the caller reports a resolved conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= ARB_PORT0;
        end else if (adv) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/std_sync_reg_2r.sv
// M-structure register: one writer, two round-robin arbitrated readers.
// Latency: done pulse registered at the edge after an eligible request; write->read turnaround 2 cycles.
// Backpressure: writes wait while FULL, reads wait while EMPTY; requests hold until done.
module std_sync_reg_2r
    import sync_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    std_sync_reg_2r_if.slave    bus
);

    sync_state_t      state_q;
    sync_state_t      state_d;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] out_0_q;
    logic [WIDTH-1:0] out_1_q;
    logic             write_done_q;
    logic             read_done_0_q;
    logic             read_done_1_q;
    logic             wr_commit;
    logic [1:0]       rd_commit;
    logic [1:0]       grant;
    logic             conflict;

    // Arbiter only advances when both readers compete for a full register.
    assign conflict = (state_q == SYNC_FULL) && bus.read_en_0 && bus.read_en_1;

    std_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.read_en_1, bus.read_en_0}),
        .adv   (conflict),
        .grant (grant)
    );

    // Next-state and commit decode; EMPTY admits only writes, FULL only reads.
    always_comb begin
        state_d   = state_q;
        wr_commit = 1'b0;
        rd_commit = 2'b00;
        unique case (state_q)
            SYNC_EMPTY: begin
                if (bus.write_en) begin
                    state_d   = SYNC_FULL;
                    wr_commit = 1'b1;
                end
            end
            SYNC_FULL: begin
                if (grant != 2'b00) begin
                    state_d   = SYNC_EMPTY;
                    rd_commit = grant;
                end
            end
            default: state_d = SYNC_EMPTY;
        endcase
    end

    // State, stored value, per-reader output data and done pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SYNC_EMPTY;
            value_q       <= '0;
            out_0_q       <= '0;
            out_1_q       <= '0;
            write_done_q  <= 1'b0;
            read_done_0_q <= 1'b0;
            read_done_1_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_done_q  <= wr_commit;
            read_done_0_q <= rd_commit[0];
            read_done_1_q <= rd_commit[1];
            if (wr_commit) begin
                value_q <= bus.in;
            end
            if (rd_commit[0]) begin
                out_0_q <= value_q;
            end
            if (rd_commit[1]) begin
                out_1_q <= value_q;
            end
        end
    end

    assign bus.out_0       = out_0_q;
    assign bus.out_1       = out_1_q;
    assign bus.write_done  = write_done_q;
    assign bus.read_done_0 = read_done_0_q;
    assign bus.read_done_1 = read_done_1_q;

endmodule

// File: tb/tb_std_sync_reg_2r.sv
// Self-checking bench for the one-writer/two-reader sync register.
// Directed scenarios plus a randomized run against a queue-based occupancy model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_std_sync_reg_2r;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    std_sync_reg_2r_if #(.WIDTH(32)) bus ();

    std_sync_reg_2r #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.in        = '0;
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b0;
        bus.read_en_1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.in        = 32'hA5A5_0001;
        bus.write_en  = 1'b1;
        bus.read_en_0 = 1'b1;
        bus.read_en_1 = 1'b1;
        reset         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b000 ||
                bus.out_0 !== 32'h0 || bus.out_1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d: dones=%b out0=%h out1=%h, want 000/0/0",
                         i, {bus.write_done, bus.read_done_0, bus.read_done_1}, bus.out_0, bus.out_1);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b100) begin
            errors++;
            $display("FAIL reset_first_edge: dones=%b, want 100",
                     {bus.write_done, bus.read_done_0, bus.read_done_1});
        end
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b0;
        bus.read_en_1 = 1'b0;
        tick();
    endtask

    task automatic test_single_reader();
        do_reset();
        bus.in       = 32'hDEAD_BEEF;
        bus.write_en = 1'b1;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b100) begin
            errors++;
            $display("FAIL single_write: dones=%b, want 100",
                     {bus.write_done, bus.read_done_0, bus.read_done_1});
        end
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b1;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b010 ||
            bus.out_0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_read: dones=%b out0=%h, want 010/deadbeef",
                     {bus.write_done, bus.read_done_0, bus.read_done_1}, bus.out_0);
        end
        bus.read_en_0 = 1'b0;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b000) begin
            errors++;
            $display("FAIL single_deassert: dones=%b, want 000",
                     {bus.write_done, bus.read_done_0, bus.read_done_1});
        end
    endtask

    task automatic test_read_blocks();
        do_reset();
        bus.read_en_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.read_done_1 !== 1'b0) begin
                errors++;
                $display("FAIL read_blocks_empty cyc=%0d: read_done_1=%b, want 0", i, bus.read_done_1);
            end
        end
        bus.in       = 32'h5;
        bus.write_en = 1'b1;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b100) begin
            errors++;
            $display("FAIL read_blocks_write: dones=%b, want 100",
                     {bus.write_done, bus.read_done_0, bus.read_done_1});
        end
        bus.write_en = 1'b0;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b001 ||
            bus.out_1 !== 32'h5) begin
            errors++;
            $display("FAIL read_blocks_read: dones=%b out1=%h, want 001/5",
                     {bus.write_done, bus.read_done_0, bus.read_done_1}, bus.out_1);
        end
        bus.read_en_1 = 1'b0;
        tick();
    endtask

    task automatic test_write_blocks();
        do_reset();
        bus.in       = 32'h7;
        bus.write_en = 1'b1;
        tick();
        checks++;
        if (bus.write_done !== 1'b1) begin
            errors++;
            $display("FAIL write_blocks_first: write_done=%b, want 1", bus.write_done);
        end
        bus.in = 32'h9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.write_done !== 1'b0) begin
                errors++;
                $display("FAIL write_blocks_full cyc=%0d: write_done=%b, want 0", i, bus.write_done);
            end
        end
        bus.read_en_0 = 1'b1;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b010 ||
            bus.out_0 !== 32'h7) begin
            errors++;
            $display("FAIL write_blocks_drain: dones=%b out0=%h, want 010/7",
                     {bus.write_done, bus.read_done_0, bus.read_done_1}, bus.out_0);
        end
        bus.read_en_0 = 1'b0;
        tick();
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b100) begin
            errors++;
            $display("FAIL write_blocks_second: dones=%b, want 100",
                     {bus.write_done, bus.read_done_0, bus.read_done_1});
        end
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b1;
        tick();
        checks++;
        if (bus.read_done_0 !== 1'b1 || bus.out_0 !== 32'h9) begin
            errors++;
            $display("FAIL write_blocks_readback: read_done_0=%b out0=%h, want 1/9",
                     bus.read_done_0, bus.out_0);
        end
        bus.read_en_0 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back_conflict();
        int   wr_i;
        int   rd_i;
        int   got_k;
        logic [31:0] got_v;
        do_reset();
        wr_i          = 0;
        rd_i          = 0;
        bus.read_en_0 = 1'b1;
        bus.read_en_1 = 1'b1;
        bus.in        = 32'd1;
        bus.write_en  = 1'b1;
        for (int cyc = 0; cyc < 40 && rd_i < 4; cyc++) begin
            tick();
            checks++;
            if ($countones({bus.write_done, bus.read_done_0, bus.read_done_1}) > 1) begin
                errors++;
                $display("FAIL conflict_onehot cyc=%0d: dones=%b, want at most one high",
                         cyc, {bus.write_done, bus.read_done_0, bus.read_done_1});
            end
            if (bus.write_done) begin
                wr_i++;
                if (wr_i < 4) bus.in = 32'(wr_i + 1);
                else bus.write_en = 1'b0;
            end
            if (bus.read_done_0 || bus.read_done_1) begin
                got_k = bus.read_done_0 ? 0 : 1;
                got_v = bus.read_done_0 ? bus.out_0 : bus.out_1;
                checks++;
                if (got_k != (rd_i % 2) || got_v !== 32'(rd_i + 1)) begin
                    errors++;
                    $display("FAIL conflict_order read#%0d: reader=%0d value=%0d, want reader=%0d value=%0d",
                             rd_i, got_k, got_v, rd_i % 2, rd_i + 1);
                end
                rd_i++;
            end
        end
        checks++;
        if (rd_i != 4) begin
            errors++;
            $display("FAIL conflict_timeout: reads=%0d, want 4", rd_i);
        end
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b0;
        bus.read_en_1 = 1'b0;
        tick();
    endtask

    task automatic test_mid_handshake_reset();
        do_reset();
        bus.in       = 32'h33;
        bus.write_en = 1'b1;
        tick();
        checks++;
        if (bus.write_done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_write: write_done=%b, want 1", bus.write_done);
        end
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== 3'b000 || bus.out_0 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async_clear: dones=%b out0=%h, want 000/0",
                     {bus.write_done, bus.read_done_0, bus.read_done_1}, bus.out_0);
        end
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.read_done_0 !== 1'b0) begin
                errors++;
                $display("FAIL midrst_read_waits cyc=%0d: read_done_0=%b, want 0", i, bus.read_done_0);
            end
        end
        bus.in       = 32'h44;
        bus.write_en = 1'b1;
        tick();
        bus.write_en = 1'b0;
        tick();
        checks++;
        if (bus.read_done_0 !== 1'b1 || bus.out_0 !== 32'h44) begin
            errors++;
            $display("FAIL midrst_after_write: read_done_0=%b out0=%h, want 1/44",
                     bus.read_done_0, bus.out_0);
        end
        bus.read_en_0 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] v;
        logic        turn;
        logic        pre_full, pw, p0, p1;
        logic        e_wd, e_r0, e_r1;
        do_reset();
        turn = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            pre_full = (q.size() != 0);
            pw       = bus.write_en;
            p0       = bus.read_en_0;
            p1       = bus.read_en_1;
            e_wd     = !pre_full && pw;
            e_r0     = pre_full && p0 && (!p1 || turn == 1'b0);
            e_r1     = pre_full && p1 && (!p0 || turn == 1'b1);
            tick();
            checks++;
            if ({bus.write_done, bus.read_done_0, bus.read_done_1} !== {e_wd, e_r0, e_r1}) begin
                errors++;
                $display("FAIL rand_done cyc=%0d: dones=%b, want %b",
                         cyc, {bus.write_done, bus.read_done_0, bus.read_done_1}, {e_wd, e_r0, e_r1});
            end
            if (e_wd) q.push_back(bus.in);
            if (e_r0 || e_r1) begin
                v = q.pop_front();
                checks++;
                if ((e_r0 ? bus.out_0 : bus.out_1) !== v) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d reader=%0d: value=%h, want %h",
                             cyc, e_r0 ? 0 : 1, e_r0 ? bus.out_0 : bus.out_1, v);
                end
                if (p0 && p1) turn = ~turn;
            end
            if (bus.write_done) begin
                bus.write_en = 1'b0;
            end else if (!bus.write_en && $urandom_range(0, 2) == 0) begin
                bus.in       = $urandom;
                bus.write_en = 1'b1;
            end
            if (bus.read_done_0) bus.read_en_0 = 1'($urandom_range(0, 1));
            else if (!bus.read_en_0 && $urandom_range(0, 3) == 0) bus.read_en_0 = 1'b1;
            if (bus.read_done_1) bus.read_en_1 = 1'($urandom_range(0, 1));
            else if (!bus.read_en_1 && $urandom_range(0, 3) == 0) bus.read_en_1 = 1'b1;
        end
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b0;
        bus.read_en_1 = 1'b0;
        tick();
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b0;
        bus.in        = '0;
        bus.write_en  = 1'b0;
        bus.read_en_0 = 1'b0;
        bus.read_en_1 = 1'b0;
        test_reset();
        test_single_reader();
        test_read_blocks();
        test_write_blocks();
        test_back_to_back_conflict();
        test_mid_handshake_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/std_sync_reg_2r.md
Name: std_sync_reg_2r

Overview:
- M-structure register with one writer and two arbitrated readers.
- A write blocks until the register is empty. A read blocks until it is full. Each successful read empties the register, so every written value is consumed exactly once.
- Used by the Calyx `par`-lowering synchronization primitives where one producer thread feeds two consumer threads.
- Companion to the two-writer/one-reader sync register; the round-robin arbitration is on the read side instead of the write side.

Parameters:
- WIDTH, 32, data width of the stored value and of each read port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in  input  WIDTH  write data; held stable from write_en rise until write_done.
- write_en  input  1  write request; held high until write_done.
- read_en_0  input  1  reader 0 request; held high until read_done_0.
- read_en_1  input  1  reader 1 request; held high until read_done_1.
- out_0  output  WIDTH  data for reader 0; valid only in the cycle read_done_0=1.
- out_1  output  WIDTH  data for reader 1; valid only in the cycle read_done_1=1.
- write_done  output  1  one-cycle pulse: write committed.
- read_done_0  output  1  one-cycle pulse: reader 0 consumed the value.
- read_done_1  output  1  one-cycle pulse: reader 1 consumed the value.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-handshake):
  - state FSM -> EMPTY, stored value -> 0, arbiter -> 0.
  - out_0, out_1 -> 0; all done outputs -> 0.
  - Requests still pending are re-evaluated on the first rising edge after reset returns to 1.
- FSM has two states, EMPTY and FULL.
  - EMPTY & write_en: next state FULL, value <= in, write_done <= 1.
  - EMPTY with no write_en: stay EMPTY. Read requests wait and no done pulse is produced.
  - FULL & exactly one read_en_k: next state EMPTY, out_k <= value, read_done_k <= 1.
  - FULL & both read_en: arbiter picks reader k = arbiter, which gets out_k and read_done_k; next state EMPTY; arbiter toggles. The loser keeps waiting and is served by the next write/read cycle.
  - FULL with no read_en: stay FULL. write_en waits and no write_done is produced.
- Arbiter: 1-bit round robin. It toggles only on a two-reader conflict; a single-reader read leaves it unchanged.
- Write and read never commit in the same cycle, because they are gated by mutually exclusive states. Minimum value turnaround is therefore 2 cycles: write commits at edge N, read commits at edge N+1.
- Latency:
  - A request presented in an eligible state gets its done pulse registered at the next rising edge.
  - All done outputs are registered and deassert the cycle after they pulse, unless a new commit occurs.
- out_k holds its last delivered value when not being written. Consumers must only sample it while read_done_k=1.
- After a read, the stored value holds the old data; it is don't-care until the next write.
- Only one done output can be high in a given cycle.
- Starvation bound: with both readers asserting continuously and the writer supplying values, each reader is served within 2 writes.

Decomposition:
- Shared package sync_pkg:
  - typedef enum logic {SYNC_EMPTY, SYNC_FULL} sync_state_t, reused by the other sync primitives.
  - 1-bit arbiter encoding constants ARB_PORT0 and ARB_PORT1.
- One natural sub-module: std_rr_arb2, a 2-requester round-robin arbiter with an advance enable. Its inputs are req[1:0] and adv; its output is a one-hot grant. It is shareable with the two-writer sync register.

Test Plan:
- Reset defaults: hold reset=0 for 3 cycles with all requests high, then release → all done outputs and out_k read 0 during reset. The first edge after release yields write_done=1 (state was EMPTY); no read_done occurs that cycle.
- Basic single-reader transfer: write in=32'hDEAD_BEEF, then raise read_en_0 → write_done pulses one cycle, read_done_0 pulses the following cycle with out_0=32'hDEADBEEF, and read_done_1 stays 0.
- Read blocks while empty: assert read_en_1 for 5 cycles with no write, then write 32'h5 → read_done_1 stays 0 for those 5 cycles. After write_done, read_done_1 pulses with out_1=5.
- Write blocks while full: write 7 with no reader, then request a write of 9 → the second write gets no write_done until reader 0 consumes 7. Its write_done lands 1 cycle after read_done_0, and the next read returns 9.
- Read conflict and fairness: hold both read_en high and write 1, 2, 3, 4 back to back → reader 0 gets 1, reader 1 gets 2, reader 0 gets 3, reader 1 gets 4. The arbiter alternates and no cycle has two done outputs high.
- Mid-handshake reset: in FULL with read_en_0 high, pulse reset low asynchronously between edges → read_done_0 and the FSM clear immediately. After release, read_en_0 waits until a new write_done.
